// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode constants, sequencer state encoding and opcode classification shared by the CPU
package ctrl_pkg;

    localparam logic [2:0] OP_HLT  = 3'd0;
    localparam logic [2:0] OP_SKZ  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_ANDD = 3'd3;
    localparam logic [2:0] OP_XORR = 3'd4;
    localparam logic [2:0] OP_LDA  = 3'd5;
    localparam logic [2:0] OP_STO  = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_EXEC3,
        ST_SKIP,
        ST_HALTED
    } state_e;

    function automatic logic is_alu_op(input logic [2:0] opc);
        return opc == OP_ADD || opc == OP_ANDD || opc == OP_XORR || opc == OP_LDA;
    endfunction

endpackage

// File: rtl/ctrl_beat_cnt.sv
// ctrl_beat_cnt: modulo-N up counter with enable, synchronous clear and terminal-count flag
module ctrl_beat_cnt #(
    parameter int N = 2,
    parameter int W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = cnt_q == W'(N - 1);
    assign cnt_o = cnt_q;

    // Wrap to zero after the terminal count so every run starts from 0
    always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;

    // Count register, advancing on the falling edge like the rest of the sequencer
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: accumulator-CPU control sequencer with multi-beat fetch, memory wait states and resumable halt
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int FETCH_BEATS = 2,
    parameter int OPC_W       = 3,
    parameter bit WAIT_EN     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OPC_W-1:0]             opcode_i,
    input  logic                         zero_i,
    input  logic                         mem_rdy_i,
    input  logic                         resume_i,
    output logic                         rd_o,
    output logic                         wr_o,
    output logic                         load_ir_o,
    output logic [$clog2(FETCH_BEATS):0] ir_beat_o,
    output logic                         load_acc_o,
    output logic                         load_pc_o,
    output logic                         incr_pc_o,
    output logic                         datactrl_ena_o,
    output logic                         halt_o,
    output logic                         instr_done_o
);

    localparam int BW = $clog2(FETCH_BEATS) + 1;

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             zero_q, zero_d;
    logic [2:0]       opc3;
    logic             rdy, known, alu, sto, jmp, skip_taken;
    logic [BW-1:0]    beat_cnt, skip_cnt_unused;
    logic             beat_tc, skip_tc;

    assign rdy        = WAIT_EN ? mem_rdy_i : 1'b1;
    assign opc3       = opc_q[2:0];
    assign known      = (opc_q >> 3) == '0;
    assign alu        = known && is_alu_op(opc3);
    assign sto        = known && opc3 == OP_STO;
    assign jmp        = known && opc3 == OP_JMP;
    assign skip_taken = known && opc3 == OP_SKZ && zero_q;

    ctrl_beat_cnt #(.N(FETCH_BEATS), .W(BW)) u_beat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .en_i  (state_q == ST_FETCH && rdy),
        .cnt_o (beat_cnt),
        .tc_o  (beat_tc)
    );

    ctrl_beat_cnt #(.N(FETCH_BEATS), .W(BW)) u_skip (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == ST_EXEC3),
        .en_i  (state_q == ST_SKIP),
        .cnt_o (skip_cnt_unused),
        .tc_o  (skip_tc)
    );

    // Sequencer state plus the opcode and zero flag captured in DECODE
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            zero_q  <= zero_d;
        end
    end

    // Next state and control strobes; a stalled state re-presents the same strobes
    always_comb begin
        state_d        = state_q;
        opc_d          = opc_q;
        zero_d         = zero_q;
        rd_o           = 1'b0;
        wr_o           = 1'b0;
        load_ir_o      = 1'b0;
        ir_beat_o      = '0;
        load_acc_o     = 1'b0;
        load_pc_o      = 1'b0;
        incr_pc_o      = 1'b0;
        datactrl_ena_o = 1'b0;
        halt_o         = 1'b0;
        instr_done_o   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                rd_o      = 1'b1;
                load_ir_o = 1'b1;
                ir_beat_o = beat_cnt;
                incr_pc_o = rdy;
                state_d   = rdy && beat_tc ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                opc_d   = opcode_i;
                zero_d  = zero_i;
                state_d = opcode_i == OPC_W'(OP_HLT) ? ST_HALTED : ST_EXEC1;
            end
            ST_EXEC1: begin
                load_pc_o      = jmp;
                rd_o           = alu;
                datactrl_ena_o = sto;
                state_d        = !alu || rdy ? ST_EXEC2 : ST_EXEC1;
            end
            ST_EXEC2: begin
                load_pc_o      = jmp;
                rd_o           = alu;
                load_acc_o     = alu;
                wr_o           = sto;
                datactrl_ena_o = sto;
                state_d        = !(alu || sto) || rdy ? ST_EXEC3 : ST_EXEC2;
            end
            ST_EXEC3: begin
                datactrl_ena_o = sto;
                instr_done_o   = !skip_taken;
                state_d        = skip_taken ? ST_SKIP : ST_FETCH;
            end
            ST_SKIP: begin
                incr_pc_o    = 1'b1;
                instr_done_o = skip_tc;
                state_d      = skip_tc ? ST_FETCH : ST_SKIP;
            end
            ST_HALTED: begin
                halt_o  = 1'b1;
                state_d = resume_i ? ST_FETCH : ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench for ctrl_seq across three parameter sets
module tb_ctrl_seq;

    localparam logic [12:0] RD   = 13'h1000;
    localparam logic [12:0] WR   = 13'h0800;
    localparam logic [12:0] IR   = 13'h0400;
    localparam logic [12:0] ACC  = 13'h0200;
    localparam logic [12:0] PC   = 13'h0100;
    localparam logic [12:0] INC  = 13'h0080;
    localparam logic [12:0] DE   = 13'h0040;
    localparam logic [12:0] HLT  = 13'h0020;
    localparam logic [12:0] DONE = 13'h0010;
    localparam logic [12:0] F    = RD | IR | INC;

    typedef struct {
        logic [12:0] e;
        int          n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_rdy = 1'b1;
    logic       resume = 1'b0;

    logic [2:0] rd, wr, ir, acc, pc, inc, de, hlt, done;
    logic [1:0] beat_a, beat_c;
    logic [2:0] beat_b;
    logic [3:0] beat4;
    logic [12:0] act;

    exp_t  exp_q[$];
    int    sel = 0;
    int    n_vec = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    string ph = "init";

    always #5 clk = ~clk;

    ctrl_seq #(.FETCH_BEATS(2), .OPC_W(3), .WAIT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode[2:0]), .zero_i(zero),
        .mem_rdy_i(mem_rdy), .resume_i(resume), .rd_o(rd[0]), .wr_o(wr[0]),
        .load_ir_o(ir[0]), .ir_beat_o(beat_a), .load_acc_o(acc[0]), .load_pc_o(pc[0]),
        .incr_pc_o(inc[0]), .datactrl_ena_o(de[0]), .halt_o(hlt[0]), .instr_done_o(done[0])
    );

    ctrl_seq #(.FETCH_BEATS(3), .OPC_W(3), .WAIT_EN(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode[2:0]), .zero_i(zero),
        .mem_rdy_i(mem_rdy), .resume_i(resume), .rd_o(rd[1]), .wr_o(wr[1]),
        .load_ir_o(ir[1]), .ir_beat_o(beat_b), .load_acc_o(acc[1]), .load_pc_o(pc[1]),
        .incr_pc_o(inc[1]), .datactrl_ena_o(de[1]), .halt_o(hlt[1]), .instr_done_o(done[1])
    );

    ctrl_seq #(.FETCH_BEATS(2), .OPC_W(4), .WAIT_EN(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .zero_i(zero),
        .mem_rdy_i(mem_rdy), .resume_i(resume), .rd_o(rd[2]), .wr_o(wr[2]),
        .load_ir_o(ir[2]), .ir_beat_o(beat_c), .load_acc_o(acc[2]), .load_pc_o(pc[2]),
        .incr_pc_o(inc[2]), .datactrl_ena_o(de[2]), .halt_o(hlt[2]), .instr_done_o(done[2])
    );

    always_comb begin
        beat4 = sel == 0 ? {2'b00, beat_a} : sel == 1 ? {1'b0, beat_b} : {2'b00, beat_c};
        act   = {rd[sel], wr[sel], ir[sel], acc[sel], pc[sel], inc[sel], de[sel],
                 hlt[sel], done[sel], beat4};
    end

    // Monitor: outputs are stable mid-cycle, so compare on the rising edge
    always @(posedge clk) begin
        exp_t it;
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            n_chk++;
            if (act !== it.e) begin
                n_fail++;
                $display("FAIL %s vec %0d: got %b want %b", ph, it.n, act, it.e);
            end
        end
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (rd[d] && wr[d]) begin
                n_fail++;
                $display("FAIL rd_wr_overlap dut %0d: got rd=1 wr=1 want not both", d);
            end
            n_chk++;
            if (pc[d] && inc[d]) begin
                n_fail++;
                $display("FAIL pc_overlap dut %0d: got load_pc=1 incr_pc=1 want not both", d);
            end
        end
    end

    task automatic push(input logic [12:0] e);
        exp_t it;
        n_vec++;
        it.e = e;
        it.n = n_vec;
        exp_q.push_back(it);
    endtask

    task automatic cyc(input logic r, input logic res, input logic [12:0] e);
        @(negedge clk);
        #1;
        mem_rdy = r;
        resume  = res;
        push(e);
    endtask

    task automatic reset_dut(input int s, input string name, input logic [3:0] op, input logic z);
        @(posedge clk);
        #1;
        ph      = name;
        sel     = s;
        n_vec   = 0;
        rst_n   = 1'b0;
        mem_rdy = 1'b1;
        resume  = 1'b0;
        opcode  = op;
        zero    = z;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        push('0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut(0, "add", 4'd2, 1'b0);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1); cyc(1, 0, '0);
        cyc(1, 0, RD); cyc(1, 0, RD | ACC); cyc(1, 0, DONE); cyc(1, 0, F | 13'd0);

        reset_dut(0, "sto", 4'd6, 1'b0);
        cyc(0, 0, RD | IR); cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1); cyc(1, 0, '0);
        cyc(1, 0, DE);
        cyc(0, 0, WR | DE); cyc(0, 0, WR | DE); cyc(0, 0, WR | DE); cyc(1, 0, WR | DE);
        cyc(1, 0, DE | DONE); cyc(1, 0, F | 13'd0);

        reset_dut(1, "skz_taken", 4'd1, 1'b1);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1); cyc(1, 0, F | 13'd2); cyc(1, 0, '0);
        cyc(1, 0, '0); cyc(1, 0, '0); cyc(1, 0, '0);
        cyc(1, 0, INC); cyc(1, 0, INC); cyc(1, 0, INC | DONE); cyc(1, 0, F | 13'd0);

        reset_dut(1, "skz_not_taken", 4'd1, 1'b0);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1); cyc(1, 0, F | 13'd2); cyc(1, 0, '0);
        cyc(1, 0, '0); cyc(1, 0, '0); cyc(1, 0, DONE); cyc(1, 0, F | 13'd0);

        reset_dut(0, "hlt", 4'd0, 1'b0);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1); cyc(1, 0, '0);
        cyc(1, 0, HLT); cyc(1, 0, HLT); cyc(1, 0, HLT); cyc(1, 0, HLT); cyc(1, 1, HLT);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1);

        reset_dut(0, "lda_reset", 4'd5, 1'b0);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1); cyc(1, 0, '0);
        cyc(0, 0, RD); cyc(1, 0, RD); cyc(1, 0, RD | ACC);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", act, 13'd0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        push('0);
        cyc(1, 0, F | 13'd0); cyc(1, 0, F | 13'd1);

        reset_dut(2, "jmp_nowait", 4'd7, 1'b0);
        cyc(0, 0, F | 13'd0); cyc(0, 0, F | 13'd1); cyc(0, 0, '0);
        cyc(0, 0, PC); cyc(0, 0, PC); cyc(0, 0, DONE); cyc(0, 0, F | 13'd0);

        reset_dut(2, "nop_wide", 4'hA, 1'b0);
        cyc(0, 0, F | 13'd0); cyc(0, 0, F | 13'd1); cyc(0, 0, '0);
        cyc(0, 0, '0); cyc(0, 0, '0); cyc(0, 0, DONE); cyc(0, 0, F | 13'd0);

        @(posedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
